// File: rtl/etc_tile_sched.sv
// etc_tile_sched: K-loop sequencer for one 4x4 extended-tensor-core tile unit.
// Streams k_tiles A/B pairs into the unit, folds the unit's output tiles into
// an accumulator (wrapping sum for op=0, unsigned max otherwise) and returns
// the reduced tile over a valid/ready port.
module etc_tile_sched #(
   parameter int W  = 16,
   parameter int KW = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [1:0]             op,
   input  logic [KW-1:0]          k_tiles,
   output logic                   busy,
   output logic                   done,
   input  logic                   tile_valid,
   output logic                   tile_ready,
   input  logic [3:0][3:0][W-1:0] tile_a,
   input  logic [3:0][3:0][W-1:0] tile_b,
   output logic [1:0]             etc_op,
   output logic [3:0][3:0][W-1:0] etc_inA,
   output logic [3:0][3:0][W-1:0] etc_inB,
   input  logic [3:0][3:0][W-1:0] etc_out,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [3:0][3:0][W-1:0] res_tile
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

   state_t                 state;
   logic [KW-1:0]          kTiles;
   logic [KW-1:0]          issueCnt;
   logic [KW-1:0]          recvCnt;
   // validPipe[0]: pair issued last cycle; validPipe[1]: etc_out valid now.
   logic [1:0]             validPipe;
   logic [3:0][3:0][W-1:0] acc;
   logic [3:0][3:0][W-1:0] accNext;
   logic                   accept;
   logic                   recv;

   assign busy       = (state != IDLE);
   assign res_valid  = (state == OUT);
   assign res_tile   = acc;
   assign tile_ready = (state == ISSUE) && (issueCnt < kTiles);
   assign accept     = tile_ready && tile_valid;
   // The unit sees zero operands on any cycle without an accepted pair.
   assign etc_inA    = accept ? tile_a : '0;
   assign etc_inB    = accept ? tile_b : '0;
   assign recv       = validPipe[1] && ((state == ISSUE) || (state == DRAIN));

   // Element-wise reduction of the unit output into the accumulator.
   always_comb begin
      accNext = acc;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (recvCnt == '0)
               accNext[i][j] = etc_out[i][j];
            else if (etc_op == 2'd0)
               accNext[i][j] = acc[i][j] + etc_out[i][j];
            else
               accNext[i][j] = (etc_out[i][j] > acc[i][j]) ? etc_out[i][j] : acc[i][j];
         end
      end
   end

   // Job FSM with issue/receive counters, latency pipeline and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         kTiles    <= '0;
         issueCnt  <= '0;
         recvCnt   <= '0;
         validPipe <= '0;
         acc       <= '0;
         etc_op    <= '0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         validPipe <= {validPipe[0], accept};
         if (accept)
            issueCnt <= issueCnt + KW'(1);
         if (recv) begin
            acc     <= accNext;
            recvCnt <= recvCnt + KW'(1);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  etc_op    <= op;
                  kTiles    <= k_tiles;
                  issueCnt  <= '0;
                  recvCnt   <= '0;
                  acc       <= '0;
                  validPipe <= '0;
                  state     <= (k_tiles == '0) ? OUT : ISSUE;
               end
            end
            ISSUE: begin
               if (accept && ((issueCnt + KW'(1)) == kTiles))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (recv && ((recvCnt + KW'(1)) == kTiles))
                  state <= OUT;
            end
            OUT: begin
               if (res_ready) begin
                  state  <= IDLE;
                  done   <= 1'b1;
                  etc_op <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
